wb_ooo_slave: RTL and testbench

Wishbone slave endpoint that sits directly downstream of the master/slave interconnect in the out-of-order testbench. It accepts tagged pipelined requests, commits writes and samples reads at acceptance, and returns tagged responses out of order. Each request is held in one of DEPTH slots for a pseudo-random (or fixed) latency. The block gives the out-of-order master sequences a real, reorder-capable target in place of a purely behavioural slave.

---
 rtl/wb_ooo_slave.sv | 143 ++++++++++++++
 tb/tb_wb_ooo_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ooo_slave.sv
// wb_ooo_slave: Wishbone pipelined slave endpoint with tagged, out-of-order
// completion. Each accepted request waits in one of DEPTH slots for a fixed or
// LFSR-derived latency. The lowest-index slot whose countdown has expired then
// responds, one response per cycle.
module wb_ooo_slave #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 16,
  parameter int          MEM_AW    = 6,
  parameter int          TAG_W     = 4,
  parameter int          DEPTH     = 4,
  parameter int          FIXED_LAT = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CYC_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [ADDR_W-1:0]     ADR_I,
  input  logic [DATA_W/8-1:0]   SEL_I,
  input  logic [DATA_W-1:0]     DAT_I,
  input  logic [TAG_W-1:0]      TGA_I,
  output logic                  STALL_O,
  output logic                  ACK_O,
  output logic                  ERR_O,
  output logic                  RTY_O,
  output logic [DATA_W-1:0]     DAT_O,
  output logic [TAG_W-1:0]      TGD_O
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  logic [DEPTH-1:0]  slot_vld;
  logic [DEPTH-1:0]  slot_err;
  logic [TAG_W-1:0]  slot_tag [DEPTH];
  logic [DATA_W-1:0] slot_dat [DEPTH];
  logic [CNT_W-1:0]  slot_cnt [DEPTH];

  logic [DATA_W-1:0] mem [2**MEM_AW];

  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;

  logic              accept;
  logic              addr_err;
  logic [MEM_AW-1:0] mem_addr;
  logic [CNT_W-1:0]  lat;
  logic [DATA_W-1:0] load_dat;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_vld;

  // Stall depends only on registered occupancy and CYC_I, never on STB_I.
  assign STALL_O   = (&slot_vld) | ~CYC_I;
  assign RTY_O     = 1'b0;
  assign accept    = CYC_I & STB_I & ~STALL_O;
  assign mem_addr  = ADR_I[MEM_AW-1:0];
  assign addr_err  = |ADR_I[ADDR_W-1:MEM_AW];
  // Galois form of the x^16+x^14+x^13+x^11+1 polynomial, shifting right.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign lat       = (FIXED_LAT != 0) ? CNT_W'(FIXED_LAT)
                                      : {1'b0, lfsr[2:0]} + CNT_W'(1);
  // Reads capture memory before this cycle's write lands, so they see old data.
  assign load_dat  = (WE_I | addr_err) ? '0 : mem[mem_addr];

  // Pick the lowest free slot for an accept and the lowest eligible slot to respond.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    free_idx = '0;
    sel_idx  = '0;
    sel_vld  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_vld[i]) free_idx = IDX_W'(i);
      if (slot_vld[i] && slot_cnt[i] == '0) begin
        sel_idx = IDX_W'(i);
        sel_vld = CYC_I;
      end
    end
  end

  // Commit non-error writes at accept time, byte-masked.
  // NOTE: the memory array is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept && WE_I && !addr_err) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (SEL_I[b]) mem[mem_addr][8*b +: 8] <= DAT_I[8*b +: 8];
      end
    end
  end

  // Slot payload: load on accept, otherwise count down while occupied.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && free_idx == IDX_W'(i)) begin
        slot_tag[i] <= TGA_I;
        slot_err[i] <= addr_err;
        slot_dat[i] <= load_dat;
        slot_cnt[i] <= lat;
      end else if (slot_vld[i] && slot_cnt[i] != '0) begin
        slot_cnt[i] <= slot_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Slot occupancy: abort clears everything, else free on response, set on accept.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) begin
      slot_vld <= '0;
    end else if (!CYC_I) begin
      slot_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_vld && sel_idx == IDX_W'(i))       slot_vld[i] <= 1'b0;
        else if (accept && free_idx == IDX_W'(i))  slot_vld[i] <= 1'b1;
      end
    end
  end

  // Latency LFSR advances once per accepted request and survives aborts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lfsr <= LFSR_SEED;
    else if (accept) lfsr <= lfsr_next;
  end

  // Registered response from the selected slot; all zero when nothing is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      DAT_O <= '0;
      TGD_O <= '0;
    end else begin
      ACK_O <= sel_vld & ~slot_err[sel_idx];
      ERR_O <= sel_vld &  slot_err[sel_idx];
      DAT_O <= sel_vld ? slot_dat[sel_idx] : '0;
      TGD_O <= sel_vld ? slot_tag[sel_idx] : '0;
    end
  end

endmodule

// File: tb/tb_wb_ooo_slave.sv
// Directed bench for wb_ooo_slave. Four instances share one stimulus bus and
// differ only in latency mode; mon_sel picks the instance each phase observes.
module tb_wb_ooo_slave;

  typedef struct packed {
    logic [31:0] c;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [3:0]  tag;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_i, stb_i, we_i;
  logic [15:0] adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [3:0]  tga_i;

  logic        stall_o [4];
  logic        ack_o   [4];
  logic        err_o   [4];
  logic        rty_o   [4];
  logic [31:0] dat_o   [4];
  logic [3:0]  tgd_o   [4];

  int          mon_sel = 0;
  logic        m_stall, m_ack, m_err, m_rty;
  logic [31:0] m_dat;
  logic [3:0]  m_tgd;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  resp_t       rq [$];
  logic        stall_log [0:1023];

  always #5 clk = ~clk;

  wb_ooo_slave #(.FIXED_LAT(3)) u_f3 (
    .clk(clk), .rst(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ADR_I(adr_i),
    .SEL_I(sel_i), .DAT_I(dat_i), .TGA_I(tga_i), .STALL_O(stall_o[0]), .ACK_O(ack_o[0]),
    .ERR_O(err_o[0]), .RTY_O(rty_o[0]), .DAT_O(dat_o[0]), .TGD_O(tgd_o[0]));
  wb_ooo_slave #(.FIXED_LAT(0), .LFSR_SEED(16'hACE1)) u_lf (
    .clk(clk), .rst(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ADR_I(adr_i),
    .SEL_I(sel_i), .DAT_I(dat_i), .TGA_I(tga_i), .STALL_O(stall_o[1]), .ACK_O(ack_o[1]),
    .ERR_O(err_o[1]), .RTY_O(rty_o[1]), .DAT_O(dat_o[1]), .TGD_O(tgd_o[1]));
  wb_ooo_slave #(.FIXED_LAT(8)) u_f8 (
    .clk(clk), .rst(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ADR_I(adr_i),
    .SEL_I(sel_i), .DAT_I(dat_i), .TGA_I(tga_i), .STALL_O(stall_o[2]), .ACK_O(ack_o[2]),
    .ERR_O(err_o[2]), .RTY_O(rty_o[2]), .DAT_O(dat_o[2]), .TGD_O(tgd_o[2]));
  wb_ooo_slave #(.FIXED_LAT(6)) u_f6 (
    .clk(clk), .rst(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ADR_I(adr_i),
    .SEL_I(sel_i), .DAT_I(dat_i), .TGA_I(tga_i), .STALL_O(stall_o[3]), .ACK_O(ack_o[3]),
    .ERR_O(err_o[3]), .RTY_O(rty_o[3]), .DAT_O(dat_o[3]), .TGD_O(tgd_o[3]));

  // Route the observed instance to the monitor signals.
  always_comb begin
    m_stall = stall_o[mon_sel];
    m_ack   = ack_o[mon_sel];
    m_err   = err_o[mon_sel];
    m_rty   = rty_o[mon_sel];
    m_dat   = dat_o[mon_sel];
    m_tgd   = tgd_o[mon_sel];
  end

  // Cycle counter: value seen during a cycle is its index.
  always @(posedge clk) cyc <= cyc + 1;

  // Log stall per cycle and every response with the cycle it appeared in.
  always @(negedge clk) begin
    stall_log[cyc % 1024] <= m_stall;
    if (rst && (m_ack || m_err)) rq.push_back('{c: cyc, ack: m_ack, err: m_err, dat: m_dat, tag: m_tgd});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic resp_t rsp(input int k);
    resp_t r;
    r = 'x;
    if (k < rq.size()) r = rq[k];
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    repeat (2) next();
    rst = 1'b1; cyc_i = 1'b1;
    next();
    rq.delete();
  endtask

  // Present a request and hold it until accepted; returns the accept cycle.
  task automatic req(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [3:0] tag, output int acc);
    we_i = we; adr_i = adr; sel_i = sel; dat_i = dat; tga_i = tag; stb_i = 1'b1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!m_stall) begin
        acc = cyc;
        next();
        break;
      end
      next();
    end
    chk("req_accepted", 32'(acc >= 0), 32'd1);
  endtask

  task automatic wait_resp(input int n, input int budget);
    for (int i = 0; i < budget && rq.size() < n; i++) next();
    chk("resp_arrived", 32'(rq.size() >= n), 32'd1);
  endtask

  initial begin
    resp_t r;
    int a, b, c;
    int acc [6];
    int exp_tag [4] = '{0, 3, 1, 2};
    int exp_off [4] = '{7, 9, 10, 12};
    int f8_off  [6] = '{10, 11, 12, 13, 20, 21};
    logic nonmono;
    logic [3:0] seen;

    // ---------------- reset / idle ----------------
    rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; sel_i = '0; dat_i = '0; tga_i = '0;
    #2;
    chk("rst_ack",   32'(m_ack),   32'd0);
    chk("rst_err",   32'(m_err),   32'd0);
    chk("rst_rty",   32'(m_rty),   32'd0);
    chk("rst_dat",   m_dat,        32'd0);
    chk("rst_tgd",   32'(m_tgd),   32'd0);
    chk("rst_stall", 32'(m_stall), 32'd1);
    repeat (2) next();
    rst = 1'b1;
    next();
    #1;
    chk("idle_stall_cyc_low", 32'(m_stall), 32'd1);
    chk("idle_ack",           32'(m_ack),   32'd0);
    cyc_i = 1'b1;
    next();
    #1;
    chk("idle_stall_cyc_high", 32'(m_stall), 32'd0);

    // ---------------- fixed latency 3 ----------------
    mon_sel = 0;
    rq.delete();
    req(1'b1, 16'd5, 4'hF, 32'hDEADBEEF, 4'd1, a);
    stb_i = 1'b0;
    wait_resp(1, 20);
    r = rsp(0);
    chk("wr_ack", 32'(r.ack), 32'd1);
    chk("wr_tag", 32'(r.tag), 32'd1);
    chk("wr_dat", r.dat,      32'd0);
    chk("wr_lat", r.c,        32'(a + 5));

    rq.delete();
    req(1'b0, 16'd5, 4'hF, 32'd0, 4'd2, a);
    stb_i = 1'b0;
    wait_resp(1, 20);
    r = rsp(0);
    chk("rd_ack", 32'(r.ack), 32'd1);
    chk("rd_tag", 32'(r.tag), 32'd2);
    chk("rd_dat", r.dat,      32'hDEADBEEF);
    chk("rd_lat", r.c,        32'(a + 5));

    rq.delete();
    req(1'b1, 16'd5, 4'b0010, 32'h00001100, 4'd3, a);
    req(1'b0, 16'd5, 4'hF,    32'd0,        4'd4, b);
    stb_i = 1'b0;
    wait_resp(2, 20);
    r = rsp(1);
    chk("bytewr_b2b",  32'(b), 32'(a + 1));
    chk("bytewr_tag",  32'(r.tag), 32'd4);
    chk("bytewr_dat",  r.dat, 32'hDEAD11EF);

    // ---------------- error ----------------
    rq.delete();
    req(1'b1, 16'd0, 4'hF, 32'h12345678, 4'd5, a);
    stb_i = 1'b0;
    wait_resp(1, 20);
    rq.delete();
    req(1'b1, 16'h0040, 4'hF, 32'hFFFFFFFF, 4'd7, a);
    stb_i = 1'b0;
    wait_resp(1, 20);
    r = rsp(0);
    chk("err_err", 32'(r.err), 32'd1);
    chk("err_ack", 32'(r.ack), 32'd0);
    chk("err_tag", 32'(r.tag), 32'd7);
    chk("err_dat", r.dat,      32'd0);
    chk("err_lat", r.c,        32'(a + 5));
    rq.delete();
    req(1'b0, 16'd0, 4'hF, 32'd0, 4'd8, a);
    stb_i = 1'b0;
    wait_resp(1, 20);
    r = rsp(0);
    chk("err_mem_kept", r.dat,      32'h12345678);
    chk("err_rd_ack",   32'(r.ack), 32'd1);

    // ---------------- out-of-order (LFSR) ----------------
    // Seed 0xACE1 gives latencies 2,1,1,5,7,8,4,...; three warm-up writes
    // consume 2,1,1 so the four reads get 5,7,8,4 -> tags return 0,3,1,2.
    mon_sel = 1;
    do_reset();
    req(1'b1, 16'd10, 4'hF, 32'h1, 4'd12, a);
    req(1'b1, 16'd11, 4'hF, 32'h2, 4'd13, a);
    req(1'b1, 16'd12, 4'hF, 32'h3, 4'd14, a);
    stb_i = 1'b0;
    wait_resp(3, 30);
    rq.delete();
    req(1'b0, 16'd0, 4'hF, 32'd0, 4'd0, a);
    for (int k = 1; k < 4; k++) req(1'b0, 16'(k), 4'hF, 32'd0, 4'(k), b);
    stb_i = 1'b0;
    wait_resp(4, 40);
    repeat (5) next();
    chk("ooo_count", 32'(rq.size()), 32'd4);
    nonmono = 1'b0;
    seen    = '0;
    for (int k = 0; k < 4; k++) begin
      r = rsp(k);
      chk($sformatf("ooo_tag%0d", k), 32'(r.tag), 32'(exp_tag[k]));
      chk($sformatf("ooo_cyc%0d", k), r.c, 32'(a + exp_off[k]));
      if (!$isunknown(r.tag)) seen[r.tag[1:0]] = 1'b1;
      if (k > 0 && r.tag < rsp(k - 1).tag) nonmono = 1'b1;
    end
    chk("ooo_nonmono",   32'(nonmono), 32'd1);
    chk("ooo_each_once", 32'(seen),    32'hF);

    // ---------------- full / stall (latency 8) ----------------
    mon_sel = 2;
    do_reset();
    for (int k = 0; k < 6; k++) req(1'b0, 16'(k), 4'hF, 32'd0, 4'(k), acc[k]);
    stb_i = 1'b0;
    wait_resp(6, 60);
    for (int k = 1; k < 4; k++) chk($sformatf("full_acc%0d", k), 32'(acc[k]), 32'(acc[0] + k));
    chk("full_acc4", 32'(acc[4]), 32'(acc[0] + 10));
    chk("full_acc5", 32'(acc[5]), 32'(acc[0] + 11));
    for (int k = 4; k < 10; k++)
      chk($sformatf("full_stall_c%0d", k), 32'(stall_log[(acc[0] + k) % 1024]), 32'd1);
    chk("full_stall_release", 32'(stall_log[(acc[0] + 10) % 1024]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      r = rsp(k);
      chk($sformatf("full_tag%0d", k), 32'(r.tag), 32'(k));
      chk($sformatf("full_cyc%0d", k), r.c, 32'(acc[0] + f8_off[k]));
    end

    // ---------------- abort (latency 6) ----------------
    mon_sel = 3;
    do_reset();
    for (int k = 1; k < 4; k++) req(1'b0, 16'(k), 4'hF, 32'd0, 4'(k), a);
    stb_i = 1'b0;
    cyc_i = 1'b0;
    #1;
    chk("abort_stall", 32'(m_stall), 32'd1);
    next();
    cyc_i = 1'b1;
    repeat (12) next();
    chk("abort_no_resp", 32'(rq.size()), 32'd0);
    for (int k = 0; k < 4; k++) req(1'b0, 16'(k), 4'hF, 32'd0, 4'(k + 4), acc[k]);
    stb_i = 1'b0;
    #1;
    chk("abort_refill_full", 32'(m_stall), 32'd1);
    for (int k = 1; k < 4; k++) chk($sformatf("abort_acc%0d", k), 32'(acc[k]), 32'(acc[0] + k));
    wait_resp(4, 30);
    for (int k = 0; k < 4; k++) begin
      r = rsp(k);
      chk($sformatf("abort_tag%0d", k), 32'(r.tag), 32'(k + 4));
      chk($sformatf("abort_cyc%0d", k), r.c, 32'(acc[k] + 8));
    end

    // ---------------- reset mid-flight ----------------
    rq.delete();
    req(1'b1, 16'd20, 4'hF, 32'hA5A5A5A5, 4'd9,  c);
    req(1'b1, 16'd21, 4'hF, 32'h5A5A5A5A, 4'd10, a);
    req(1'b1, 16'd22, 4'hF, 32'h0F0F0F0F, 4'd11, a);
    stb_i = 1'b0;
    for (int i = 0; i < 20 && cyc < c + 8; i++) next();
    chk("mid_pre_ack", 32'(m_ack), 32'd1);
    chk("mid_pre_tgd", 32'(m_tgd), 32'd9);
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(m_ack), 32'd0);
    chk("mid_rst_err", 32'(m_err), 32'd0);
    chk("mid_rst_tgd", 32'(m_tgd), 32'd0);
    chk("mid_rst_dat", m_dat,      32'd0);
    repeat (2) next();
    rst = 1'b1;
    repeat (12) next();
    chk("mid_dropped", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
